// File: rtl/layer_pkg.sv
// Shared types for the layer serializer slice.
// Holds the default word width and the sender state encoding.
package layer_pkg;

  localparam int DEF_DATA_WIDTH = 16;

  typedef enum logic {
    IDLE,
    SEND
  } ser_state_t;

endpackage

// File: rtl/layer_collect.sv
// Collector: gathers per-neuron words until every mask bit is set.
// Ports: clk, rst, i_valid/i_data (per-neuron), i_clear (transfer),
//        o_cbuf (held words), o_full, o_ovf (LAYER_SER_OVF_EN only).
module layer_collect
  import layer_pkg::*;
#(
  parameter int NN         = 30,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NN-1:0]                   i_valid,
  input  logic [NN*DATA_WIDTH-1:0]        i_data,
  input  logic                            i_clear,
  output logic [NN-1:0][DATA_WIDTH-1:0]   o_cbuf,
  output logic                            o_full
`ifdef LAYER_SER_OVF_EN
  ,
  output logic                            o_ovf
`endif
);

  logic [NN-1:0]                 r_mask;
  logic [NN-1:0][DATA_WIDTH-1:0] r_cbuf;
  logic [NN-1:0]                 w_take;

  // On a transfer every slot is free again, so any strobe is taken.
  assign w_take = i_clear ? i_valid : (i_valid & ~r_mask);
  assign o_full = &r_mask;
  assign o_cbuf = r_cbuf;

  always_ff @(posedge clk) begin
    if (rst)
      r_mask <= '0;
    else if (i_clear)
      r_mask <= i_valid;
    else
      r_mask <= r_mask | i_valid;
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NN; k++)
      if (w_take[k])
        r_cbuf[k] <= i_data[k*DATA_WIDTH +: DATA_WIDTH];
  end

`ifdef LAYER_SER_OVF_EN
  logic r_ovf;
  logic w_drop;

  assign w_drop = !i_clear && |(i_valid & r_mask);
  assign o_ovf  = r_ovf;

  always_ff @(posedge clk) begin
    if (rst)
      r_ovf <= 1'b0;
    else if (w_drop)
      r_ovf <= 1'b1;
  end
`endif

endmodule

// File: rtl/layer_serializer.sv
// Double-buffered serializer: collects NN words, streams them in order.
// Ports: clk, rst, x_valid, x_in, out_valid, out_data, busy, ovf (LAYER_SER_OVF_EN).
module layer_serializer
  import layer_pkg::*;
#(
  parameter int NN         = 30,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NN-1:0]            x_valid,
  input  logic [NN*DATA_WIDTH-1:0] x_in,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     busy
`ifdef LAYER_SER_OVF_EN
  ,
  output logic                     ovf
`endif
);

  localparam int CW = (NN > 1) ? $clog2(NN) : 1;

  ser_state_t                    r_state;
  logic [CW-1:0]                 r_cnt;
  logic [NN-1:0][DATA_WIDTH-1:0] r_sbuf;
  logic                          r_out_valid;
  logic [DATA_WIDTH-1:0]         r_out_data;

  logic [NN-1:0][DATA_WIDTH-1:0] w_cbuf;
  logic                          w_full;
  logic                          w_last;
  logic                          w_xfer;
  logic [CW-1:0]                 w_cnt_nxt;

  layer_collect #(
    .NN         (NN),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_collect (
    .clk     (clk),
    .rst     (rst),
    .i_valid (x_valid),
    .i_data  (x_in),
    .i_clear (w_xfer),
    .o_cbuf  (w_cbuf),
    .o_full  (w_full)
`ifdef LAYER_SER_OVF_EN
    ,
    .o_ovf   (ovf)
`endif
  );

  assign w_last    = (r_state == SEND) && (r_cnt == CW'(NN - 1));
  assign w_xfer    = w_full && ((r_state == IDLE) || w_last);
  assign w_cnt_nxt = r_cnt + 1'b1;

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = (r_state == SEND);

  always_ff @(posedge clk) begin
    if (w_xfer)
      r_sbuf <= w_cbuf;
  end

  // Word 0 is taken straight from the collector on transfer so the
  // first word appears the cycle after transfer with no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_xfer) begin
      r_state     <= SEND;
      r_cnt       <= '0;
      r_out_valid <= 1'b1;
      r_out_data  <= w_cbuf[0];
    end else if (r_state == SEND) begin
      if (w_last) begin
        r_state     <= IDLE;
        r_cnt       <= '0;
        r_out_valid <= 1'b0;
        r_out_data  <= '0;
      end else begin
        r_cnt       <= w_cnt_nxt;
        r_out_data  <= r_sbuf[w_cnt_nxt];
      end
    end
  end

endmodule

// File: tb/tb_layer_serializer.sv
// Scoreboard bench for layer_serializer (NN=4): directed scenarios
// followed by randomized collection traffic against a frame-level model.
module tb_layer_serializer;

  localparam int NN = 4;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NN-1:0]     x_valid = '0;
  logic [NN*DW-1:0]  x_in = '0;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic              busy;
`ifdef LAYER_SER_OVF_EN
  logic              ovf;
`endif

  layer_serializer #(.NN(NN), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .x_valid   (x_valid),
    .x_in      (x_in),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy)
`ifdef LAYER_SER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a collected frame (words + present flags) and the
  // number of words the sender still owes from the frame it is sending.
  logic [DW-1:0] m_buf [NN];
  logic [NN-1:0] m_have = '0;
  int            m_rem = 0;
  bit            m_ovf = 0;
  bit            m_rstd = 0;
  bit            m_on = 0;
  logic [DW-1:0] expq [$];

  always @(posedge clk) begin
    if (rst) begin
      m_rem = 0;
      m_have = '0;
      m_ovf = 0;
      m_rstd = 1;
      m_on = 1;
      expq.delete();
    end else begin
      m_rstd = 0;
      if ((&m_have) && m_rem <= 1) begin
        for (int k = 0; k < NN; k++) expq.push_back(m_buf[k]);
        m_rem = NN;
        m_have = '0;
        for (int k = 0; k < NN; k++)
          if (x_valid[k]) begin
            m_buf[k] = x_in[k*DW +: DW];
            m_have[k] = 1'b1;
          end
      end else begin
        if (m_rem > 0) m_rem--;
        for (int k = 0; k < NN; k++)
          if (x_valid[k]) begin
            if (m_have[k]) m_ovf = 1;
            else begin
              m_buf[k] = x_in[k*DW +: DW];
              m_have[k] = 1'b1;
            end
          end
      end
    end
  end

  // Monitor: samples on the falling edge, pops expected words on out_valid.
  always @(negedge clk) begin
    if (m_on) begin
      n_cmp++;
      if (out_valid !== (m_rem > 0)) begin
        n_err++;
        $display("FAIL out_valid t=%0t got %b want %b", $time, out_valid, m_rem > 0);
      end
      n_cmp++;
      if (busy !== (m_rem > 0)) begin
        n_err++;
        $display("FAIL busy t=%0t got %b want %b", $time, busy, m_rem > 0);
      end
      if (m_rstd) begin
        n_cmp++;
        if (out_data !== '0) begin
          n_err++;
          $display("FAIL reset_data t=%0t got %h want 0000", $time, out_data);
        end
      end
`ifdef LAYER_SER_OVF_EN
      n_cmp++;
      if (ovf !== m_ovf) begin
        n_err++;
        $display("FAIL ovf t=%0t got %b want %b", $time, ovf, m_ovf);
      end
`endif
      if (out_valid === 1'b1) begin
        n_cmp++;
        if (expq.size() == 0) begin
          n_err++;
          $display("FAIL data_extra t=%0t got %h want none", $time, out_data);
        end else begin
          logic [DW-1:0] e;
          e = expq.pop_front();
          if (out_data !== e) begin
            n_err++;
            $display("FAIL data t=%0t got %h want %h", $time, out_data, e);
          end
        end
      end
    end
  end

  task automatic cyc(input logic [NN-1:0] xv, input logic [NN*DW-1:0] d);
    x_valid = xv;
    x_in = d;
    @(posedge clk);
    #1;
    x_valid = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc('0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [NN*DW-1:0] d;
    logic [NN-1:0]    xv;
    do_reset();

    // Single frame, all strobes together.
    cyc(4'b1111, {16'h0044, 16'h0033, 16'h0022, 16'h0011});
    idle(8);

    // Staggered arrival.
    cyc(4'b1000, {16'hA004, 16'h0, 16'h0, 16'h0});
    idle(2);
    cyc(4'b0010, {16'h0, 16'h0, 16'hA002, 16'h0});
    idle(3);
    cyc(4'b0101, {16'h0, 16'hA003, 16'h0, 16'hA001});
    idle(8);

    // Back-to-back frames.
    cyc(4'b1111, {16'h1004, 16'h1003, 16'h1002, 16'h1001});
    idle(2);
    cyc(4'b1111, {16'h2004, 16'h2003, 16'h2002, 16'h2001});
    idle(12);

    // Duplicate strobe on neuron 2 before the frame completes.
    cyc(4'b0100, {16'h0, 16'h5555, 16'h0, 16'h0});
    cyc(4'b0100, {16'h0, 16'hBEEF, 16'h0, 16'h0});
    cyc(4'b1011, {16'h3004, 16'h0, 16'h3002, 16'h3001});
    idle(8);

    // Reset during the second word of a frame.
    do_reset();
    cyc(4'b1111, {16'h4004, 16'h4003, 16'h4002, 16'h4001});
    idle(2);
    do_reset();
    idle(2);
    cyc(4'b1111, {16'h6004, 16'h6003, 16'h6002, 16'h6001});
    idle(8);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        xv = ($urandom_range(0, 5) == 0) ? '1 : NN'($urandom);
        if ($urandom_range(0, 2) == 0) xv = '0;
        d = {$urandom, $urandom};
        cyc(xv, d);
      end
    end
    idle(12);

    n_cmp++;
    if (expq.size() != 0) begin
      n_err++;
      $display("FAIL drain got %0d left want 0", expq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
